// File: rtl/regfile_writeback_ctrl.sv
// regfile_writeback_ctrl
//   Write-side controller for the 32x32 register file. Buffers one writeback
//   request per source (load, jal link, ALU), arbitrates among them and drives
//   the single register-file write port with at most one registered write per
//   clock. Two combinational bypass queries return the youngest value not yet
//   committed to the register file.
//
// Ports
//   clk, reset                      clock, async active-high reset
//   alu_valid/ready/dest/data/funct ALU result request (funct 8 = jr, no write)
//   ld_valid/ready/dest/data        load result request
//   link_valid/ready/link_pc        jal link request, writes link_pc+4 to LINK_REG
//   RegWrite/inC/out                registered register-file write port
//   q_rs_addr/hit/data              bypass query A
//   q_rt_addr/hit/data              bypass query B
module regfile_writeback_ctrl #(
  parameter int         STARVE_LIMIT = 4,
  parameter logic [4:0] LINK_REG     = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_dest,
  input  logic [31:0] alu_data,
  input  logic [5:0]  alu_funct,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_dest,
  input  logic [31:0] ld_data,
  input  logic        link_valid,
  output logic        link_ready,
  input  logic [31:0] link_pc,
  output logic        RegWrite,
  output logic [4:0]  inC,
  output logic [31:0] out,
  input  logic [4:0]  q_rs_addr,
  output logic        q_rs_hit,
  output logic [31:0] q_rs_data,
  input  logic [4:0]  q_rt_addr,
  output logic        q_rt_hit,
  output logic [31:0] q_rt_data
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_INIT = SW'(STARVE_LIMIT);
  localparam int LD = 0;
  localparam int LK = 1;
  localparam int AL = 2;

  logic [2:0]    hold_v;
  logic [4:0]    hold_dest   [3];
  logic [31:0]   hold_data   [3];
  // Down-counter of losses still tolerated; zero means the entry is starved.
  logic [SW-1:0] starve_left [3];
  // age_q[0]: load older than link, [1]: load older than alu, [2]: link older than alu
  logic [2:0]    age_q;

  // older[i][j] = entry i is older than entry j (only meaningful when both held)
  logic [2:0]    older [3];
  logic [2:0]    eligible;
  logic [2:0]    starved;
  logic [2:0]    grant;
  logic [2:0]    acc;
  logic [2:0]    keep;
  logic [4:0]    new_dest [3];
  logic [31:0]   new_data [3];
  logic [4:0]    win_dest;
  logic [31:0]   win_data;

  assign older[LD] = {age_q[1], age_q[0], 1'b0};
  assign older[LK] = {age_q[2], 1'b0, ~age_q[0]};
  assign older[AL] = {1'b0, ~age_q[2], ~age_q[1]};

  always_comb begin
    eligible = '0;
    starved  = '0;
    for (int i = 0; i < 3; i++) begin
      eligible[i] = hold_v[i];
      // an older pending write to the same register must commit first
      for (int j = 0; j < 3; j++) begin
        if (j != i && hold_v[j] && hold_dest[j] == hold_dest[i] && older[j][i])
          eligible[i] = 1'b0;
      end
      starved[i] = eligible[i] && (starve_left[i] == '0);
    end

    grant = '0;
    if (starved != '0) begin
      if (starved[LD])      grant[LD] = 1'b1;
      else if (starved[LK]) grant[LK] = 1'b1;
      else                  grant[AL] = 1'b1;
    end else if (eligible[LD]) begin
      grant[LD] = 1'b1;
    end else if (eligible[LK]) begin
      grant[LK] = 1'b1;
    end else if (eligible[AL]) begin
      grant[AL] = 1'b1;
    end
  end

  always_comb begin
    win_dest = '0;
    win_data = '0;
    for (int i = 0; i < 3; i++) begin
      if (grant[i]) begin
        win_dest = hold_dest[i];
        win_data = hold_data[i];
      end
    end
  end

  assign ld_ready   = ~reset & (~hold_v[LD] | grant[LD]);
  assign link_ready = ~reset & (~hold_v[LK] | grant[LK]);
  assign alu_ready  = ~reset & (~hold_v[AL] | grant[AL]);

  assign acc[LD] = ld_valid & ld_ready;
  assign acc[LK] = link_valid & link_ready;
  assign acc[AL] = alu_valid & alu_ready;

  // jr and writes to r0 are accepted but never occupy an entry
  assign keep[LD] = acc[LD] & (ld_dest != 5'd0);
  assign keep[LK] = acc[LK] & (LINK_REG != 5'd0);
  assign keep[AL] = acc[AL] & (alu_funct != 6'd8) & (alu_dest != 5'd0);

  assign new_dest[LD] = ld_dest;
  assign new_dest[LK] = LINK_REG;
  assign new_dest[AL] = alu_dest;
  assign new_data[LD] = ld_data;
  assign new_data[LK] = link_pc + 32'd4;
  assign new_data[AL] = alu_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_v   <= '0;
      age_q    <= '0;
      RegWrite <= 1'b0;
      inC      <= '0;
      out      <= '0;
      for (int i = 0; i < 3; i++) begin
        hold_dest[i]   <= '0;
        hold_data[i]   <= '0;
        starve_left[i] <= STARVE_INIT;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (keep[i]) begin
          hold_v[i]      <= 1'b1;
          hold_dest[i]   <= new_dest[i];
          hold_data[i]   <= new_data[i];
          starve_left[i] <= STARVE_INIT;
        end else if (grant[i]) begin
          hold_v[i]      <= 1'b0;
          starve_left[i] <= STARVE_INIT;
        end else if (hold_v[i] && starve_left[i] != '0) begin
          starve_left[i] <= starve_left[i] - SW'(1);
        end
      end

      // A newly loaded entry is younger than anything already held; among
      // same-edge loads the lower source index is the older one.
      if (keep[LD] | keep[LK]) age_q[0] <= keep[LK];
      if (keep[LD] | keep[AL]) age_q[1] <= keep[AL];
      if (keep[LK] | keep[AL]) age_q[2] <= keep[AL];

      if (grant != '0) begin
        RegWrite <= 1'b1;
        inC      <= win_dest;
        out      <= win_data;
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

  logic [4:0]  q_addr [2];
  logic [1:0]  q_hit;
  logic [31:0] q_data [2];

  assign q_addr[0] = q_rs_addr;
  assign q_addr[1] = q_rt_addr;

  always_comb begin
    logic [2:0] match;
    logic       youngest;
    match    = '0;
    youngest = 1'b0;
    q_hit    = '0;
    for (int q = 0; q < 2; q++) begin
      q_data[q] = '0;
      for (int i = 0; i < 3; i++)
        match[i] = hold_v[i] && (hold_dest[i] == q_addr[q]) && (q_addr[q] != 5'd0);
      for (int i = 0; i < 3; i++) begin
        youngest = 1'b1;
        for (int j = 0; j < 3; j++) begin
          if (j != i && match[j] && older[i][j])
            youngest = 1'b0;
        end
        if (match[i] && youngest) begin
          q_hit[q]  = 1'b1;
          q_data[q] = hold_data[i];
        end
      end
      if (!q_hit[q] && RegWrite && (inC == q_addr[q]) && (q_addr[q] != 5'd0)) begin
        q_hit[q]  = 1'b1;
        q_data[q] = out;
      end
    end
  end

  assign q_rs_hit  = q_hit[0];
  assign q_rs_data = q_data[0];
  assign q_rt_hit  = q_hit[1];
  assign q_rt_data = q_data[1];

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
module tb_regfile_writeback_ctrl;

  logic        clk;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic [5:0]  alu_funct;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_dest;
  logic [31:0] ld_data;
  logic        link_valid, link_ready;
  logic [31:0] link_pc;
  logic        RegWrite;
  logic [4:0]  inC;
  logic [31:0] out;
  logic [4:0]  q_rs_addr, q_rt_addr;
  logic        q_rs_hit, q_rt_hit;
  logic [31:0] q_rs_data, q_rt_data;

  regfile_writeback_ctrl dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest),
    .alu_data(alu_data), .alu_funct(alu_funct),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_data(ld_data),
    .link_valid(link_valid), .link_ready(link_ready), .link_pc(link_pc),
    .RegWrite(RegWrite), .inC(inC), .out(out),
    .q_rs_addr(q_rs_addr), .q_rs_hit(q_rs_hit), .q_rs_data(q_rs_data),
    .q_rt_addr(q_rt_addr), .q_rt_hit(q_rt_hit), .q_rt_data(q_rt_data)
  );

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every write seen on the port must be the next expected one.
  always @(negedge clk) begin
    if (!reset && RegWrite === 1'b1) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_dest", 64'(inC), 64'(e.dest));
        chk("wr_data", 64'(out), 64'(e.data));
      end
    end
  end

  initial begin
    int k, c, t_acc, t_wr;
    logic a_ld, a_al;

    reset = 1'b1;
    alu_valid = 0; alu_dest = 0; alu_data = 0; alu_funct = 0;
    ld_valid = 0; ld_dest = 0; ld_data = 0;
    link_valid = 0; link_pc = 0;
    q_rs_addr = 0; q_rt_addr = 0;

    #2;
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_inc", 64'(inC), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_alu_ready", 64'(alu_ready), 64'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("post_rst_readies", 64'({ld_ready, link_ready, alu_ready}), 64'b111);

    // 1: single ALU write
    alu_valid = 1; alu_dest = 5; alu_data = 32'hDEADBEEF; alu_funct = 0;
    q_rs_addr = 5;
    chk("t1_ready", 64'(alu_ready), 64'd1);
    sb.push_back('{dest: 5'd5, data: 32'hDEADBEEF});
    tick();
    alu_valid = 0;
    chk("t1_no_write_yet", 64'(RegWrite), 64'd0);
    chk("t1_byp_hold", 64'({q_rs_hit, q_rs_data}), {31'd0, 1'b1, 32'hDEADBEEF});
    tick();
    chk("t1_write", 64'({RegWrite, inC, out}), 64'({1'b1, 5'd5, 32'hDEADBEEF}));
    chk("t1_byp_outreg", 64'({q_rs_hit, q_rs_data}), {31'd0, 1'b1, 32'hDEADBEEF});
    tick();
    chk("t1_write_done", 64'(RegWrite), 64'd0);
    chk("t1_byp_miss", 64'({q_rs_hit, q_rs_data}), 64'd0);

    // 2: all three sources on the same edge
    alu_valid = 1; alu_dest = 3; alu_data = 32'hA0A0_0003;
    ld_valid = 1; ld_dest = 4; ld_data = 32'hB0B0_0004;
    link_valid = 1; link_pc = 32'h0000_0400;
    sb.push_back('{dest: 5'd4, data: 32'hB0B0_0004});
    sb.push_back('{dest: 5'd31, data: 32'h0000_0404});
    sb.push_back('{dest: 5'd3, data: 32'hA0A0_0003});
    tick();
    alu_valid = 0; ld_valid = 0; link_valid = 0;
    chk("t2_alu_ready_c0", 64'(alu_ready), 64'd0);
    chk("t2_link_ready_c0", 64'(link_ready), 64'd0);
    tick();
    chk("t2_first", 64'(inC), 64'd4);
    chk("t2_alu_ready_c1", 64'(alu_ready), 64'd0);
    tick();
    chk("t2_second", 64'({inC, out}), 64'({5'd31, 32'h0000_0404}));
    chk("t2_alu_ready_c2", 64'(alu_ready), 64'd1);
    tick();
    chk("t2_third", 64'({RegWrite, inC}), 64'({1'b1, 5'd3}));
    tick();
    chk("t2_idle", 64'(RegWrite), 64'd0);

    // 3: jr and r0 writes are swallowed
    alu_valid = 1; alu_dest = 7; alu_data = 32'h7777_7777; alu_funct = 6'd8;
    chk("t3_ready", 64'(alu_ready), 64'd1);
    tick();
    alu_dest = 0; alu_data = 32'h1234_5678; alu_funct = 0;
    tick();
    alu_valid = 0;
    q_rs_addr = 7; q_rt_addr = 0;
    chk("t3_byp_r7", 64'({q_rs_hit, q_rs_data}), 64'd0);
    chk("t3_byp_r0", 64'({q_rt_hit, q_rt_data}), 64'd0);
    chk("t3_no_write", 64'(RegWrite), 64'd0);
    tick();
    chk("t3_no_write2", 64'(RegWrite), 64'd0);
    chk("t3_ready_after", 64'(alu_ready), 64'd1);

    // 4a: load and ALU to r9 on the same edge; ALU is the younger
    ld_valid = 1; ld_dest = 9; ld_data = 32'h1111_1111;
    alu_valid = 1; alu_dest = 9; alu_data = 32'h2222_2222;
    q_rs_addr = 9; q_rt_addr = 9;
    sb.push_back('{dest: 5'd9, data: 32'h1111_1111});
    sb.push_back('{dest: 5'd9, data: 32'h2222_2222});
    tick();
    ld_valid = 0; alu_valid = 0;
    chk("t4a_byp_rs", 64'({q_rs_hit, q_rs_data}), {31'd0, 1'b1, 32'h2222_2222});
    tick();
    chk("t4a_load_first", 64'({inC, out}), 64'({5'd9, 32'h1111_1111}));
    chk("t4a_byp_rt", 64'({q_rt_hit, q_rt_data}), {31'd0, 1'b1, 32'h2222_2222});
    tick();
    chk("t4a_alu_second", 64'({inC, out}), 64'({5'd9, 32'h2222_2222}));
    tick();

    // 4b: older ALU r9 blocks a younger higher-priority load r9
    alu_valid = 1; alu_dest = 9; alu_data = 32'h3333_3333;
    link_valid = 1; link_pc = 32'h0000_1000;
    sb.push_back('{dest: 5'd31, data: 32'h0000_1004});
    sb.push_back('{dest: 5'd9, data: 32'h3333_3333});
    sb.push_back('{dest: 5'd9, data: 32'h4444_4444});
    tick();
    alu_valid = 0; link_valid = 0;
    ld_valid = 1; ld_dest = 9; ld_data = 32'h4444_4444;
    chk("t4b_ld_ready", 64'(ld_ready), 64'd1);
    tick();
    ld_valid = 0;
    chk("t4b_link", 64'(inC), 64'd31);
    chk("t4b_byp_young_ld", 64'({q_rs_hit, q_rs_data}), {31'd0, 1'b1, 32'h4444_4444});
    tick();
    chk("t4b_alu_override", 64'({inC, out}), 64'({5'd9, 32'h3333_3333}));
    tick();
    chk("t4b_load_last", 64'({inC, out}), 64'({5'd9, 32'h4444_4444}));
    tick();

    // 5: load stream starving one ALU entry
    for (int i = 0; i < 4; i++) sb.push_back('{dest: 5'd10, data: 32'h5000 + i});
    sb.push_back('{dest: 5'd11, data: 32'h0000_0A11});
    for (int i = 4; i < 8; i++) sb.push_back('{dest: 5'd10, data: 32'h5000 + i});
    k = 0; c = 0; t_acc = -1; t_wr = -1;
    ld_valid = 1; ld_dest = 10; ld_data = 32'h5000;
    alu_valid = 1; alu_dest = 11; alu_data = 32'h0000_0A11;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (k == 8 && !alu_valid && sb.size() == 0) break;
      a_ld = ld_valid & ld_ready;
      a_al = alu_valid & alu_ready;
      tick();
      c++;
      if (a_al) begin alu_valid = 0; t_acc = c; end
      if (a_ld) begin
        k++;
        if (k == 8) ld_valid = 0;
        else ld_data = 32'h5000 + 32'(k);
      end
      if (RegWrite && inC == 5'd11) t_wr = c;
    end
    chk("t5_alu_written", 64'(t_wr > 0 && t_acc > 0), 64'd1);
    chk("t5_latency_bound", 64'((t_wr - t_acc) <= 6), 64'd1);
    chk("t5_drained", 64'(sb.size()), 64'd0);
    tick();

    // 6: reset with all three entries pending
    ld_valid = 1; ld_dest = 12; ld_data = 32'hC0C0_000C;
    link_valid = 1; link_pc = 32'h0000_2000;
    alu_valid = 1; alu_dest = 13; alu_data = 32'hD0D0_000D;
    chk("t6_readies", 64'({ld_ready, link_ready, alu_ready}), 64'b111);
    tick();
    ld_valid = 0; link_valid = 0; alu_valid = 0;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_port", 64'({RegWrite, inC, out}), 64'd0);
    chk("t6_rst_ready", 64'({ld_ready, link_ready, alu_ready}), 64'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("t6_ready_after", 64'({ld_ready, link_ready, alu_ready}), 64'b111);
    q_rs_addr = 12; q_rt_addr = 13;
    chk("t6_byp_rs", 64'({q_rs_hit, q_rs_data}), 64'd0);
    chk("t6_byp_rt", 64'({q_rt_hit, q_rt_data}), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_write", 64'(RegWrite), 64'd0);
    end

    chk("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
